// File: rtl/act_led_pkg.sv
// Shared types for the drive-activity LED shaper: channel FSM states and
// the output-priority selection used to build the active-low LED drive.
package act_led_pkg;

   // Per-channel blink state.
   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_ON   = 2'd1,
      CH_GAP  = 2'd2
   } chan_state_e;

   // Which source owns the LED pins this cycle, highest priority first.
   typedef enum logic [1:0] {
      OUT_TEST  = 2'd0,   // lamp test: everything lit
      OUT_BLANK = 2'd1,   // SGPIO stream lost: everything dark
      OUT_FSM   = 2'd2    // normal: channel FSM decides
   } out_sel_e;

   function automatic out_sel_e out_select(input logic led_test, input logic link_ok);
      if (led_test)
         return OUT_TEST;
      else if (!link_ok)
         return OUT_BLANK;
      else
         return OUT_FSM;
   endfunction

   // Active-low cathode drive for one channel (0 = lit).
   function automatic logic led_drive(input out_sel_e sel, input logic lit);
      case (sel)
         OUT_TEST:  return 1'b0;
         OUT_BLANK: return 1'b1;
         default:   return ~lit;
      endcase
   endfunction

endpackage

// File: rtl/act_led_chan.sv
// One activity channel: IDLE -> ON (stretched) -> GAP (forced off) with a
// pending flag so activity seen during ON/GAP produces another blink.
module act_led_chan
   import act_led_pkg::*;
#(
   parameter int STRETCH_MS = 50,
   parameter int GAP_MS     = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic act,
   input  logic kill,
   output logic lit
);

   localparam int MAXLD = (STRETCH_MS > GAP_MS) ? STRETCH_MS : GAP_MS;
   localparam int CW    = $clog2(MAXLD + 1);
   localparam logic [CW-1:0] LOAD_ON  = CW'(STRETCH_MS);
   localparam logic [CW-1:0] LOAD_GAP = CW'(GAP_MS);

   chan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic [CW-1:0] cnt_dec;

   assign cnt_dec = cnt_q - CW'(1);

   // Next-state: a tick that empties the counter moves on in the same edge;
   // the entry cycle into ON ignores tick because the load wins.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      if (kill) begin
         state_d = CH_IDLE;
         cnt_d   = '0;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            CH_IDLE: begin
               if (act || pend_q) begin
                  state_d = CH_ON;
                  cnt_d   = LOAD_ON;
                  pend_d  = 1'b0;
               end
            end
            CH_ON: begin
               if (act) pend_d = 1'b1;
               if (tick && (cnt_q != '0)) begin
                  cnt_d = cnt_dec;
                  if (cnt_dec == '0) begin
                     state_d = CH_GAP;
                     cnt_d   = LOAD_GAP;
                  end
               end
            end
            CH_GAP: begin
               if (act) pend_d = 1'b1;
               if (tick && (cnt_q != '0)) begin
                  cnt_d = cnt_dec;
                  if (cnt_dec == '0) state_d = CH_IDLE;
               end
            end
            default: state_d = CH_IDLE;
         endcase
      end
   end

   // State, counter and pending flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CH_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   assign lit = (state_q == CH_ON);

endmodule

// File: rtl/act_led_shaper.sv
// Drive-activity LED shaper: 1 ms prescaler, SGPIO frame watchdog, N_DRV
// blink channels and a registered active-low output mux.
module act_led_shaper
   import act_led_pkg::*;
#(
   parameter int N_DRV      = 36,
   parameter int TICK_DIV   = 33000,
   parameter int STRETCH_MS = 50,
   parameter int GAP_MS     = 50,
   parameter int LOSS_MS    = 500
) (
   input  logic             SYSCLK,
   input  logic             RESET_N,
   input  logic [N_DRV-1:0] ACT_IN,
   input  logic             FRAME_STB,
   input  logic             LED_TEST,
   output logic [N_DRV-1:0] ACT_LED_L,
   output logic             LINK_OK
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int WW = $clog2(LOSS_MS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [WW-1:0] WD_LIMIT   = WW'(LOSS_MS);

   logic [PW-1:0]    presc_q, presc_d;
   logic [WW-1:0]    wd_q, wd_d;
   logic             link_q, link_d;
   logic [N_DRV-1:0] led_q, led_d;
   logic [N_DRV-1:0] lit;
   logic             tick;
   logic             kill;
   out_sel_e         out_sel;

   assign tick    = (presc_q == PRESC_LAST);
   assign kill    = ~link_q;
   assign out_sel = out_select(LED_TEST, link_q);

   // Free-running ms prescaler.
   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // Frame watchdog: a frame strobe beats a same-cycle expiry.
   always_comb begin
      wd_d   = wd_q;
      link_d = link_q;
      if (FRAME_STB) begin
         wd_d   = '0;
         link_d = 1'b1;
      end else if (tick && (wd_q != WD_LIMIT)) begin
         wd_d = wd_q + WW'(1);
         if (wd_d == WD_LIMIT) link_d = 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_DRV; gi++) begin : g_chan
         act_led_chan #(
            .STRETCH_MS(STRETCH_MS),
            .GAP_MS    (GAP_MS)
         ) u_chan (
            .clk  (SYSCLK),
            .rst_n(RESET_N),
            .tick (tick),
            .act  (ACT_IN[gi]),
            .kill (kill),
            .lit  (lit[gi])
         );
      end
   endgenerate

   // Output mux ahead of the pin register.
   always_comb begin
      led_d = '1;
      for (int i = 0; i < N_DRV; i++) led_d[i] = led_drive(out_sel, lit[i]);
   end

   // Prescaler, watchdog, link flag and pin registers.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         presc_q <= '0;
         wd_q    <= '0;
         link_q  <= 1'b0;
         led_q   <= '1;
      end else begin
         presc_q <= presc_d;
         wd_q    <= wd_d;
         link_q  <= link_d;
         led_q   <= led_d;
      end
   end

   assign ACT_LED_L = led_q;
   assign LINK_OK   = link_q;

endmodule

// File: tb/tb_act_led_shaper.sv
// Bench for act_led_shaper: directed scenarios plus random traffic, checked
// every cycle against a deadline-based model (edges at which ON/GAP/link end).
module tb_act_led_shaper;

   localparam int N  = 36;
   localparam int TD = 4;
   localparam int S  = 3;
   localparam int G  = 2;
   localparam int L  = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] act = '0;
   logic         frame = 1'b0;
   logic         test = 1'b0;
   logic [N-1:0] led;
   logic         link;

   always #5 clk = ~clk;

   act_led_shaper #(
      .N_DRV(N), .TICK_DIV(TD), .STRETCH_MS(S), .GAP_MS(G), .LOSS_MS(L)
   ) dut (
      .SYSCLK(clk), .RESET_N(rst_n), .ACT_IN(act), .FRAME_STB(frame),
      .LED_TEST(test), .ACT_LED_L(led), .LINK_OK(link)
   );

   int checks = 0;
   int failures = 0;

   // Model: m_e counts edges since reset release; ms ticks land on edges
   // that are multiples of TD. Each channel remembers the edge its current
   // ON or GAP period ends.
   int           m_e;
   int           m_mode[N];   // 0 idle, 1 on, 2 gap
   int           m_end[N];
   bit           m_pend[N];
   bit           m_link;
   int           m_loss;
   logic [N-1:0] m_led;

   bit auto_frame = 1'b0;
   bit force_frame = 1'b0;
   int fcnt = 0;

   function automatic int next_tick(input int e);
      return (e / TD + 1) * TD;
   endfunction

   task automatic model_reset();
      m_e = 0; m_link = 1'b0; m_loss = -1; m_led = '1;
      for (int i = 0; i < N; i++) begin
         m_mode[i] = 0; m_end[i] = 0; m_pend[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] on_vec;
      bit link_old;
      link_old = m_link;
      m_e++;
      for (int i = 0; i < N; i++) on_vec[i] = (m_mode[i] == 1);
      m_led = test ? '0 : (!link_old ? '1 : ~on_vec);
      for (int i = 0; i < N; i++) begin
         if (!link_old) begin
            m_mode[i] = 0; m_pend[i] = 1'b0;
         end else if (m_mode[i] == 0) begin
            if (act[i] || m_pend[i]) begin
               m_mode[i] = 1; m_pend[i] = 1'b0;
               m_end[i] = next_tick(m_e) + (S - 1) * TD;
            end
         end else begin
            if (act[i]) m_pend[i] = 1'b1;
            if (m_e == m_end[i]) begin
               if (m_mode[i] == 1) begin
                  m_mode[i] = 2;
                  m_end[i] = next_tick(m_e) + (G - 1) * TD;
               end else begin
                  m_mode[i] = 0;
               end
            end
         end
      end
      if (frame) begin
         m_link = 1'b1;
         m_loss = next_tick(m_e) + (L - 1) * TD;
      end else if (m_e == m_loss) begin
         m_link = 1'b0;
      end
   endtask

   task automatic chk(input string tag);
      checks++;
      assert (led === m_led) else begin
         failures++;
         $error("FAIL %s led obs=%h exp=%h", tag, led, m_led);
      end
      checks++;
      assert (link === m_link) else begin
         failures++;
         $error("FAIL %s link obs=%b exp=%b", tag, link, m_link);
      end
   endtask

   // One clock: drive frame, clock, update model, compare #1 after the edge.
   task automatic step(input string tag);
      fcnt++;
      frame = force_frame || (auto_frame && (fcnt % 20 == 0));
      @(posedge clk);
      model_edge();
      #1;
      chk(tag);
      force_frame = 1'b0;
   endtask

   int low_cnt;

   initial begin
      model_reset();
      // 1: reset state, then activity without frames stays dark.
      repeat (3) @(posedge clk);
      #2;
      checks++;
      assert (led === '1) else begin failures++; $error("FAIL rst_led obs=%h exp=%h", led, {N{1'b1}}); end
      checks++;
      assert (link === 1'b0) else begin failures++; $error("FAIL rst_link obs=%b exp=0", link); end
      rst_n = 1'b1;
      act = '1;
      repeat (60) step("nolink");

      // 2: frames every 20 cycles, single pulse on bit 5.
      act = '0;
      auto_frame = 1'b1;
      repeat (25) step("linkup");
      act[5] = 1'b1;
      step("pulse5");
      act[5] = 1'b0;
      low_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         step("pulse5_run");
         if (led[5] === 1'b0) low_cnt++;
      end
      checks++;
      assert (low_cnt >= 9 && low_cnt <= 12) else begin
         failures++; $error("FAIL ontime5 obs=%0d exp=9..12", low_cnt);
      end

      // 3: held activity on bit 0 blinks.
      act[0] = 1'b1;
      repeat (60) step("held0");
      act[0] = 1'b0;
      repeat (25) step("idle0");

      // 4: re-trigger bit 7 during ON and during GAP.
      act[7] = 1'b1; step("b7_first"); act[7] = 1'b0;
      repeat (5) step("b7_on");
      act[7] = 1'b1; step("b7_in_on"); act[7] = 1'b0;
      repeat (9) step("b7_wait");
      act[7] = 1'b1; step("b7_in_gap"); act[7] = 1'b0;
      repeat (45) step("b7_tail");

      // Random traffic, random frames and occasional lamp test.
      auto_frame = 1'b0;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) act[i] = ($urandom_range(15) == 0);
         test = ($urandom_range(31) == 0);
         force_frame = ($urandom_range(24) == 0);
         step("random");
      end
      act = '0; test = 1'b0;

      // 5: frame loss with activity held, then recovery.
      force_frame = 1'b1; step("relink");
      act = '1;
      repeat (60) step("loss");
      checks++;
      assert (link === 1'b0 && led === '1) else begin
         failures++; $error("FAIL loss obs=%b/%h exp=0/all1", link, led);
      end
      force_frame = 1'b1; step("recover");
      repeat (30) step("recover_run");

      // Frame strobe on the exact expiry edge keeps the link.
      act = '0;
      for (int k = 0; k < 100 && (m_e + 1 != m_loss); k++) step("to_expiry");
      force_frame = 1'b1; step("frame_at_expiry");
      checks++;
      assert (link === 1'b1) else begin failures++; $error("FAIL frame_wins obs=%b exp=1", link); end
      repeat (50) step("expire");

      // 6: lamp test during link loss, then async reset while lit.
      test = 1'b1;
      step("ledtest");
      checks++;
      assert (led === '0) else begin failures++; $error("FAIL ledtest obs=%h exp=0", led); end
      repeat (3) step("ledtest_hold");
      test = 1'b0;
      force_frame = 1'b1; step("relink2");
      act[3] = 1'b1; step("b3"); act[3] = 1'b0;
      repeat (4) step("b3_on");
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      assert (led === '1) else begin failures++; $error("FAIL async_rst_led obs=%h exp=all1", led); end
      checks++;
      assert (link === 1'b0) else begin failures++; $error("FAIL async_rst_link obs=%b exp=0", link); end
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (10) step("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
